// File: rtl/dsram_arbiter_pkg.sv
// Shared definitions for the data-SRAM arbiter: port IDs, owner register
// layout and reset values, starvation counter width and default limit.
package dsram_arbiter_pkg;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int STARVE_MAX_DEF = 4;
   localparam int STARVE_W       = 4;   // holds limits up to 15

   // Which port owns the read data returning from the SRAM next cycle.
   typedef struct packed {
      logic valid;
      logic port;
   } owner_t;

   localparam owner_t OWNER_RST      = '{valid: 1'b0, port: PORT_I};
   localparam logic   HOLD_VALID_RST = 1'b0;

   // Saturating increment for the starvation counter.
   function automatic logic [STARVE_W-1:0] starve_inc(
      input logic [STARVE_W-1:0] cnt,
      input logic [STARVE_W-1:0] lim
   );
      return (cnt >= lim) ? lim : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/dsram_rsp_hold.sv
// Single-entry response holding register. Read data arriving while the
// requester is stalled is captured and re-presented until accepted.
module dsram_rsp_hold
   import dsram_arbiter_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          full
);

   logic          buf_valid_q, buf_valid_d;
   logic [DW-1:0] buf_data_q,  buf_data_d;

   // Present buffered data first, otherwise pass the live SRAM data through;
   // capture live data when the requester cannot take it.
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_data_d  = buf_data_q;
      out_valid   = 1'b0;
      out_data    = '0;
      if (buf_valid_q) begin
         out_valid = 1'b1;
         out_data  = buf_data_q;
         if (out_ready) begin
            buf_valid_d = 1'b0;
         end
      end else if (in_valid) begin
         out_valid = 1'b1;
         out_data  = in_data;
         if (!out_ready) begin
            buf_valid_d = 1'b1;
            buf_data_d  = in_data;
         end
      end
   end

   // Buffer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_q <= HOLD_VALID_RST;
         buf_data_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_data_q  <= buf_data_d;
      end
   end

   assign full = buf_valid_q;

endmodule

// File: rtl/dsram_arbiter.sv
// Single-port data-SRAM arbiter between the fetch (I) and memory-stage (D)
// requesters. D wins by default; an I request that has lost STARVE_MAX
// consecutive cycles is forced to win. Read data returns one cycle after
// the grant and is routed to the port recorded in the owner register.
// Optional build macro DSRAM_ARB_PERF_EN adds grant/conflict/starve counters.
module dsram_arbiter
   import dsram_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF,
   parameter int AW         = 32,
   parameter int DW         = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [DW-1:0] i_rdata,
   input  logic          i_rready,
   input  logic          d_req,
   input  logic [3:0]    d_wen,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   input  logic          d_rready,
   output logic          sram_en,
   output logic [3:0]    sram_wen,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_wdata,
   input  logic [DW-1:0] sram_rdata
`ifdef DSRAM_ARB_PERF_EN
   ,
   output logic [31:0]   perf_i_gnt,
   output logic [31:0]   perf_d_gnt,
   output logic [31:0]   perf_conflict,
   output logic [31:0]   perf_starve_force
`endif
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   owner_t                owner_q, owner_d;
   logic [STARVE_W-1:0]   starve_q, starve_d;

   logic          i_rsp, d_rsp;
   logic          i_full, d_full;
   logic          i_hvalid, d_hvalid;
   logic [DW-1:0] i_hdata, d_hdata;
   logic          i_elig, d_elig, force_i;
   logic          i_win, d_win;

   // A response is in flight for a port when the owner register names it.
   assign i_rsp = owner_q.valid && (owner_q.port == PORT_I) && !rst;
   assign d_rsp = owner_q.valid && (owner_q.port == PORT_D) && !rst;

   // A port may not be granted while its data is parked or about to be parked.
   assign i_elig  = i_req && !i_full && !(i_rsp && !i_rready) && !rst;
   assign d_elig  = d_req && !d_full && !(d_rsp && !d_rready) && !rst;
   assign force_i = (starve_q == STARVE_LIM);

   // Arbitration and SRAM command mux.
   always_comb begin
      i_win      = 1'b0;
      d_win      = 1'b0;
      sram_en    = 1'b0;
      sram_wen   = 4'b0000;
      sram_addr  = '0;
      sram_wdata = '0;
      if (i_elig && (!d_elig || force_i)) begin
         i_win     = 1'b1;
         sram_en   = 1'b1;
         sram_addr = i_addr;
      end else if (d_elig) begin
         d_win      = 1'b1;
         sram_en    = 1'b1;
         sram_wen   = d_wen;
         sram_addr  = d_addr;
         sram_wdata = d_wdata;
      end
   end

   // Owner of next cycle's read data and starvation counter update.
   always_comb begin
      owner_d  = OWNER_RST;
      starve_d = starve_q;
      if (i_win) begin
         owner_d = '{valid: 1'b1, port: PORT_I};
      end else if (d_win && (d_wen == 4'b0000)) begin
         owner_d = '{valid: 1'b1, port: PORT_D};
      end
      if (!i_req || i_win) begin
         starve_d = '0;
      end else if (i_elig) begin
         starve_d = starve_inc(starve_q, STARVE_LIM);
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q  <= OWNER_RST;
         starve_q <= '0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   dsram_rsp_hold #(.DW(DW)) u_i_hold (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (i_rsp),
      .in_data   (sram_rdata),
      .out_ready (i_rready),
      .out_valid (i_hvalid),
      .out_data  (i_hdata),
      .full      (i_full)
   );

   dsram_rsp_hold #(.DW(DW)) u_d_hold (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (d_rsp),
      .in_data   (sram_rdata),
      .out_ready (d_rready),
      .out_valid (d_hvalid),
      .out_data  (d_hdata),
      .full      (d_full)
   );

   assign i_gnt    = i_win;
   assign d_gnt    = d_win;
   assign i_rvalid = i_hvalid && !rst;
   assign d_rvalid = d_hvalid && !rst;
   assign i_rdata  = rst ? '0 : i_hdata;
   assign d_rdata  = rst ? '0 : d_hdata;

`ifdef DSRAM_ARB_PERF_EN
   logic [31:0] perf_i_gnt_q, perf_i_gnt_d;
   logic [31:0] perf_d_gnt_q, perf_d_gnt_d;
   logic [31:0] perf_conflict_q, perf_conflict_d;
   logic [31:0] perf_starve_force_q, perf_starve_force_d;

   // Event counters; a forced win is an I grant while D was also eligible.
   always_comb begin
      perf_i_gnt_d        = perf_i_gnt_q + {31'd0, i_win};
      perf_d_gnt_d        = perf_d_gnt_q + {31'd0, d_win};
      perf_conflict_d     = perf_conflict_q + {31'd0, (i_elig && d_elig)};
      perf_starve_force_d = perf_starve_force_q + {31'd0, (i_win && d_elig)};
   end

   // Perf counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_i_gnt_q        <= '0;
         perf_d_gnt_q        <= '0;
         perf_conflict_q     <= '0;
         perf_starve_force_q <= '0;
      end else begin
         perf_i_gnt_q        <= perf_i_gnt_d;
         perf_d_gnt_q        <= perf_d_gnt_d;
         perf_conflict_q     <= perf_conflict_d;
         perf_starve_force_q <= perf_starve_force_d;
      end
   end

   assign perf_i_gnt        = perf_i_gnt_q;
   assign perf_d_gnt        = perf_d_gnt_q;
   assign perf_conflict     = perf_conflict_q;
   assign perf_starve_force = perf_starve_force_q;
`endif

endmodule

// File: tb/tb_dsram_arbiter.sv
// Directed bench for dsram_arbiter: a behavioural SRAM, directed stimulus
// with per-cycle grant checks, and a monitor that checks returned read data
// against per-port expected queues.
module tb_dsram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_gnt, i_rvalid, i_rready;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_gnt, d_rvalid, d_rready;
   logic [3:0]  d_wen;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr, sram_wdata, sram_rdata;
`ifdef DSRAM_ARB_PERF_EN
   logic [31:0] perf_i_gnt, perf_d_gnt, perf_conflict, perf_starve_force;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_i_q[$];
   logic [31:0] exp_d_q[$];
   logic [31:0] mem [logic [31:0]];

   dsram_arbiter #(.STARVE_MAX(4), .AW(32), .DW(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_gnt      (i_gnt),
      .i_rvalid   (i_rvalid),
      .i_rdata    (i_rdata),
      .i_rready   (i_rready),
      .d_req      (d_req),
      .d_wen      (d_wen),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .d_rready   (d_rready),
      .sram_en    (sram_en),
      .sram_wen   (sram_wen),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
`ifdef DSRAM_ARB_PERF_EN
      ,
      .perf_i_gnt        (perf_i_gnt),
      .perf_d_gnt        (perf_d_gnt),
      .perf_conflict     (perf_conflict),
      .perf_starve_force (perf_starve_force)
`endif
   );

   // Clock.
   always #5 clk = ~clk;

   // Behavioural SRAM: read data appears the cycle after a read enable.
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_wen == 4'b0000) begin
            sram_rdata <= mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
         end else begin
            logic [31:0] w;
            w = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
            for (int b = 0; b < 4; b++) begin
               if (sram_wen[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
            end
            mem[sram_addr] = w;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare presented read data with the head of each port queue;
   // pop only when the port accepts it.
   always @(negedge clk) begin
      if (i_rvalid) begin
         if (exp_i_q.size() == 0) begin
            chk("i_rvalid_unexpected", {31'd0, i_rvalid}, 32'd0);
         end else begin
            chk("i_rdata", i_rdata, exp_i_q[0]);
            if (i_rready) void'(exp_i_q.pop_front());
         end
      end
      if (d_rvalid) begin
         if (exp_d_q.size() == 0) begin
            chk("d_rvalid_unexpected", {31'd0, d_rvalid}, 32'd0);
         end else begin
            chk("d_rdata", d_rdata, exp_d_q[0]);
            if (d_rready) void'(exp_d_q.pop_front());
         end
      end
   end

   // Run bound.
   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      mem[32'h0000_0000] = 32'h1111_0000;
      mem[32'h0000_0004] = 32'h2222_0004;
      mem[32'h0000_0100] = 32'hDEAD_BEEF;
      mem[32'h0000_0300] = 32'hCAFE_0001;
      mem[32'h0000_0304] = 32'h0BAD_F00D;
      sram_rdata = 32'h0;
      rst = 1'b1;
      i_req = 1'b1; i_addr = 32'h100; i_rready = 1'b1;
      d_req = 1'b1; d_wen = 4'h0; d_addr = 32'h300; d_wdata = 32'h0; d_rready = 1'b1;

      // Reset: requests present but nothing granted or returned.
      tick();
      @(negedge clk);
      chk("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
      chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("rst_sram_en", {31'd0, sram_en}, 32'd0);
      chk("rst_sram_wen", {28'd0, sram_wen}, 32'd0);
      chk("rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
      chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      tick();
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
      tick();

      // Single I read.
      i_req = 1'b1; i_addr = 32'h100;
      @(negedge clk);
      chk("t1_i_gnt", {31'd0, i_gnt}, 32'd1);
      chk("t1_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("t1_sram_en", {31'd0, sram_en}, 32'd1);
      chk("t1_sram_addr", sram_addr, 32'h100);
      chk("t1_sram_wen", {28'd0, sram_wen}, 32'd0);
      exp_i_q.push_back(32'hDEAD_BEEF);
      tick();
      i_req = 1'b0;
      @(negedge clk);
      chk("t1_idle_sram_en", {31'd0, sram_en}, 32'd0);
      tick();

      // D partial write: same-cycle SRAM command, no read response.
      d_req = 1'b1; d_wen = 4'b0011; d_addr = 32'h200; d_wdata = 32'h1234_5678;
      @(negedge clk);
      chk("t2_d_gnt", {31'd0, d_gnt}, 32'd1);
      chk("t2_sram_wen", {28'd0, sram_wen}, 32'h3);
      chk("t2_sram_addr", sram_addr, 32'h200);
      chk("t2_sram_wdata", sram_wdata, 32'h1234_5678);
      tick();
      d_req = 1'b0; d_wen = 4'b0000;
      tick();
      tick();

      // Continuous contention: D wins four cycles, I forced on the fifth.
      i_req = 1'b1; i_addr = 32'h0;
      d_req = 1'b1; d_addr = 32'h200;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k % 5 == 4) begin
            chk("t3_i_forced", {31'd0, i_gnt}, 32'd1);
            chk("t3_d_lost", {31'd0, d_gnt}, 32'd0);
            exp_i_q.push_back(32'h1111_0000);
         end else begin
            chk("t3_d_gnt", {31'd0, d_gnt}, 32'd1);
            chk("t3_i_lost", {31'd0, i_gnt}, 32'd0);
            exp_d_q.push_back(32'h0000_5678);
         end
         tick();
      end
      i_req = 1'b0; d_req = 1'b0;
      tick();
      tick();
`ifdef DSRAM_ARB_PERF_EN
      chk("perf_starve_force", perf_starve_force, 32'd2);
      chk("perf_conflict", perf_conflict, 32'd10);
`endif

      // D read stalled three cycles; D blocked while held, I still served.
      d_rready = 1'b0; d_req = 1'b1; d_addr = 32'h300;
      @(negedge clk);
      chk("t4_d_gnt", {31'd0, d_gnt}, 32'd1);
      exp_d_q.push_back(32'hCAFE_0001);
      tick();
      d_addr = 32'h304;
      @(negedge clk);
      chk("t4_d_blocked1", {31'd0, d_gnt}, 32'd0);
      tick();
      i_req = 1'b1; i_addr = 32'h100;
      @(negedge clk);
      chk("t4_d_blocked2", {31'd0, d_gnt}, 32'd0);
      chk("t4_i_gnt", {31'd0, i_gnt}, 32'd1);
      exp_i_q.push_back(32'hDEAD_BEEF);
      tick();
      i_req = 1'b0;
      @(negedge clk);
      chk("t4_d_blocked3", {31'd0, d_gnt}, 32'd0);
      tick();
      d_rready = 1'b1;
      @(negedge clk);
      chk("t4_d_blocked4", {31'd0, d_gnt}, 32'd0);
      tick();
      @(negedge clk);
      chk("t4_d_regrant", {31'd0, d_gnt}, 32'd1);
      chk("t4_regrant_addr", sram_addr, 32'h304);
      exp_d_q.push_back(32'h0BAD_F00D);
      tick();
      d_req = 1'b0;
      tick();

      // Back-to-back I reads.
      i_req = 1'b1; i_addr = 32'h0;
      @(negedge clk);
      chk("t5_i_gnt0", {31'd0, i_gnt}, 32'd1);
      exp_i_q.push_back(32'h1111_0000);
      tick();
      i_addr = 32'h4;
      @(negedge clk);
      chk("t5_i_gnt1", {31'd0, i_gnt}, 32'd1);
      chk("t5_sram_addr1", sram_addr, 32'h4);
      exp_i_q.push_back(32'h2222_0004);
      tick();
      i_req = 1'b0;
      tick();
      tick();

      // Reset with a D read in flight and the starvation counter at 3.
      i_req = 1'b1; i_addr = 32'h100;
      d_req = 1'b1; d_wen = 4'hF; d_addr = 32'h400; d_wdata = 32'hA5A5_A5A5;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t6_d_wr_gnt", {31'd0, d_gnt}, 32'd1);
         tick();
      end
      d_wen = 4'h0; d_addr = 32'h300;
      @(negedge clk);
      chk("t6_d_rd_gnt", {31'd0, d_gnt}, 32'd1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_i_gnt", {31'd0, i_gnt}, 32'd0);
      chk("t6_rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("t6_rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("t6_rst_sram_en", {31'd0, sram_en}, 32'd0);
      tick();
      rst = 1'b0; d_wen = 4'hF; d_addr = 32'h400;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk("t6_post_d_rvalid", {31'd0, d_rvalid}, 32'd0);
            chk("t6_post_i_rvalid", {31'd0, i_rvalid}, 32'd0);
         end
         if (k == 4) begin
            chk("t6_i_forced", {31'd0, i_gnt}, 32'd1);
            exp_i_q.push_back(32'hDEAD_BEEF);
         end else begin
            chk("t6_d_gnt", {31'd0, d_gnt}, 32'd1);
         end
         tick();
      end
      i_req = 1'b0; d_req = 1'b0; d_wen = 4'h0;
      tick();
      tick();
      tick();

      chk("i_queue_drained", exp_i_q.size(), 32'd0);
      chk("d_queue_drained", exp_d_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dsram_arbiter.md
Name: dsram_arbiter

Overview:
Single-port data-SRAM arbiter between two requesters: the fetch side (I port) and the memory-stage side (D port). It drives the shared sram_* interface and routes read data back to the requester that issued the read, which arrives one cycle later. A per-port response holding register lets a stalled requester accept its data later. A starvation counter guarantees that the I port gets serviced while D-port traffic is continuous.

Parameters:
STARVE_MAX, 4, consecutive cycles an I request may lose before it is forced to win (range 1..15)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
i_req  in  1  I-port read request, held until granted
i_addr  in  AW  I-port byte address
i_gnt  out  1  I request accepted this cycle
i_rvalid  out  1  I read data valid
i_rdata  out  DW  I read data
i_rready  in  1  I port accepts read data this cycle
d_req  in  1  D-port request, held until granted
d_wen  in  4  D byte write enables; 0 = read
d_addr  in  AW  D-port byte address
d_wdata  in  DW  D write data
d_gnt  out  1  D request accepted this cycle
d_rvalid  out  1  D read data valid (reads only)
d_rdata  out  DW  D read data
d_rready  in  1  D port accepts read data
sram_en  out  1  SRAM enable, high = access this cycle
sram_wen  out  4  SRAM byte write enables
sram_addr  out  AW  SRAM address
sram_wdata  out  DW  SRAM write data
sram_rdata  in  DW  SRAM read data, valid the cycle after a read enable

Behaviour:
- Reset (rst=1 at posedge) clears owner register, both hold buffers, starvation counter and perf counters. During and after reset: gnt, rvalid, sram_en and sram_wen are 0; rdata is 0.
- A port is eligible when its req=1 and its hold buffer is empty.
- Grant is combinational in the same cycle. At most one grant per cycle.
- Arbitration rule: D wins by default. I wins if only I is eligible, or if starve_cnt==STARVE_MAX.
- starve_cnt: +1 in a cycle where I is eligible and not granted (saturates at STARVE_MAX). Cleared when I is granted or i_req=0.
- On grant, sram_en=1 and addr/wdata come from the winner. sram_wen=d_wen for D, 0 for I. With no grant, sram_en=0 and sram_wen=0.
- D write (d_wen!=0) completes at grant. It produces no rvalid and does not change the owner register.
- Read grant sets owner register {valid, port} for the next cycle.
- Response cycle (owner valid):
  - sram_rdata is presented on that port's rdata with rvalid=1.
  - If that port's rready=0, the data is captured into its hold buffer.
- Hold buffer full: rvalid=1 and rdata = buffer contents. The buffer clears on the cycle rready=1.
- Back-to-back reads to one port are allowed: a new grant may coincide with the response cycle, since owner is overwritten for the following cycle.
- A new grant to a port is blocked while a response is pending for it and its rready=0 in that cycle.
- Simultaneous I and D requests with starve_cnt<STARVE_MAX: D granted, I held, counter increments.
- Requests dropped before grant are ignored; no state is affected.
- Reset mid-response: in-flight data is discarded; rvalid=0 on the following cycle.
- Read latency: 1 cycle from grant to rvalid when rready=1.

Optional Feature:
DSRAM_ARB_PERF_EN:
- Defined: adds 32-bit wrapping counters perf_i_gnt, perf_d_gnt, perf_conflict (both eligible) and perf_starve_force (forced I wins). These are exposed as output ports, cleared by rst, and incremented on the cycle of the event.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared defines header: port-ID encodings (PORT_I=0, PORT_D=1), reset values for owner and buffers, STARVE_MAX default.
- One sub-module: dsram_rsp_hold (DW-wide single-entry hold buffer with valid/ready), instantiated once per port.
- Arbitration and the starvation counter stay in the top module.

Test Plan:
- I read addr 0x100, SRAM returns 0xDEADBEEF, i_rready=1 -> i_gnt cycle N; i_rvalid=1, i_rdata=0xDEADBEEF at N+1; d_* idle.
- D write d_wen=4'b0011, addr 0x200, data 0x12345678 -> sram_wen=4'b0011, sram_addr=0x200 same cycle; no d_rvalid afterwards.
- i_req and d_req both held continuously with STARVE_MAX=4 -> D granted 4 cycles, I granted on the 5th, pattern repeats; perf_starve_force increments (if enabled).
- D read with d_rready=0 for 3 cycles, SRAM data 0xCAFE0001 -> d_rvalid held high with 0xCAFE0001 for 3 cycles; no d_gnt while held; released on d_rready=1.
- Back-to-back I reads 0x0, 0x4 with rready=1 -> grants at N, N+1; rvalid at N+1, N+2 with correct data in order.
- rst asserted during a pending response -> next cycle i_rvalid=d_rvalid=0, sram_en=0, starve_cnt=0.
